sram1p_bwe: RTL and testbench
=============================

Name: sram1p_bwe

Overview:
- Synchronous single-port SRAM behavioural model with byte write enables. It backs the cache data subarray (64x128) and the tag/valid/dirty arrays (64x22 for RV32, 64x44 for RV64).
- The address is sampled on the clock edge into an enable-gated address register. Read data is driven from the array at the registered address.
- One model covers both the byte-multiple and the non-byte-multiple width configurations.

Parameters:
- DEPTH, 64, number of words; must be a power of two, minimum 2.
- WIDTH, 128, bits per word; any value 1 or greater, need not be a multiple of 8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- ce  input  1  chip enable; gates the address-register update and the write.
- addr  input  $clog2(DEPTH)  word address.
- din  input  WIDTH  write data.
- we  input  1  write enable; only effective when ce=1.
- bwe  input  (WIDTH-1)/8+1  byte write enables; bit i covers din[8i+7:8i].
- dout  output  WIDTH  read data.

Behaviour:
- Address register addrd:
  - Cleared to 0 on any rising clk edge with reset_n=0.
  - Otherwise loads addr when ce=1 and holds when ce=0.
  - Reset has priority over ce.
- Read:
  - dout is combinational: dout = RAM[addrd].
  - Read latency is one clock edge after addr is presented with ce=1.
  - dout follows any later change to the contents of RAM[addrd], including writes made while ce=0 on later cycles.
- Write:
  - On a rising clk edge with reset_n=1, ce=1 and we=1, for each i < WIDTH/8 with bwe[i]=1: RAM[addr][8i+7:8i] <= din[8i+7:8i].
  - If WIDTH%8 != 0, the top partial lane RAM[addr][WIDTH-1:WIDTH-WIDTH%8] is written when bwe[WIDTH/8]=1.
  - Lanes whose bwe bit is 0 keep their old value.
  - we=1 with all bwe bits 0 is a no-op.
  - ce=0 blocks writes regardless of we.
- Read/write to the same address on the same edge: the array and addrd both update at that edge. After the edge, dout shows the newly written bytes merged with the unwritten old bytes (write-through).
- Read/write to different addresses on the same edge: dout after the edge shows RAM[new addr] including any write made at that edge.
- Reset:
  - Writes are suppressed on any edge with reset_n=0.
  - Array contents are not cleared by reset.
  - After reset, dout = RAM[0].
- Initial contents: all words are X unless preloaded (see Optional Feature). Unwritten lanes read X.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- No X handling or assertions are required on the control inputs.
- Implementation:
  - The address register must be built from the team's enable-flop primitive extended with synchronous reset, or an equivalent behavioural flop.
  - Byte-lane writes and the partial-lane write may be separate clocked processes. Use plain always @(posedge clk), not always_ff, so the array can have multiple drivers.

Optional Feature:
- Macro SRAM1P_BWE_PRELOAD_EN.
- When defined:
  - At time 0, RAM[0] is initialised to 64'h00600100d2e3ca40, truncated to WIDTH or zero-extended above bit 63.
  - All other words are initialised to 0.
  - Reset still does not alter contents.
- When undefined, the array starts all-X.

Test Plan:
- WIDTH=128 full write then read: ce=1, we=1, bwe=16'hFFFF, addr=5, din=128'h0123..CDEF. Then ce=1, we=0, addr=5. The next cycle dout equals the written value.
- WIDTH=128 partial write: preload addr 7 with all-F. Write din=0 with bwe=16'h00F0. Read addr 7 -> 128'hFFFF...FFFF_00000000_FFFFFFFF, i.e. bytes 4-7 zero and all other bytes F.
- WIDTH=22 partial lane: write addr 63, din=22'h3FFFFF, bwe=3'b111. Then write din=0 with bwe=3'b100. dout -> 22'h00FFFF; bits 21:16 cleared, bits 15:0 retained.
- ce gating:
  - Write addr 1 = A, then set ce=0, we=1, addr=2, din=B. Addr 2 is unchanged and dout still shows A.
  - Then, with ce=0, a prior write to addr 1 made under ce=1 is visible on dout.
- Reset: write addr 9, then assert reset_n=0 for 2 cycles with ce=1, we=1, addr=3. Addr 3 is not written, addr 9 is retained, and dout = RAM[0] after reset. With SRAM1P_BWE_PRELOAD_EN and WIDTH=128, dout = 128'h00600100d2e3ca40.
- Same-address read/write: after reading addr 4 (old=X1), write addr 4 with new data and bwe all-ones, ce=1. dout shows the new data immediately after that edge.

Source files
------------

// File: rtl/sram1p_bwe.sv
`default_nettype none
// ============================================================================
// Module   : sram1p_bwe
// Brief    : Single-port synchronous SRAM with a registered read address and
//            byte write enables. The top lane may be narrower than 8 bits.
//            Define SRAM1P_BWE_PRELOAD_EN to start from known contents.
// Revision : 1.0 - initial release
// ============================================================================
module sram1p_bwe #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     we,
    input  logic [(WIDTH-1)/8:0]     bwe,
    output logic [WIDTH-1:0]         dout
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addrd_d;
    logic [ADDR_W-1:0] addrd_q;
    logic [WIDTH-1:0]  wmask;
    logic              wr_en;

`ifdef SRAM1P_BWE_PRELOAD_EN
    localparam logic [WIDTH-1:0] PRELOAD_WORD0 = WIDTH'(64'h00600100d2e3ca40);
    logic [WIDTH-1:0] mem [DEPTH] = '{0: PRELOAD_WORD0, default: '0};
`else
    logic [WIDTH-1:0] mem [DEPTH];
`endif

    // Every data bit follows the enable of the byte lane it lives in; the
    // partial top lane falls out of the same rule.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mask
        assign wmask[b] = bwe[b/8];
    end

    assign wr_en = reset_n & ce & we;

    always_comb begin
        addrd_d = addrd_q;
        if (ce) begin
            addrd_d = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addrd_q <= '0;
        end else begin
            addrd_q <= addrd_d;
        end
    end

    // Lanes with a clear enable are rewritten with their own value.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
        end
    end

    // Combinational read reflects any later write to the held address.
    assign dout = mem[addrd_q];

endmodule
`default_nettype wire

// File: tb/tb_sram1p_bwe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram1p_bwe
// Brief    : Self-checking bench for sram1p_bwe at WIDTH=128 and WIDTH=22,
//            against a bit-level reference memory with known-bit tracking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram1p_bwe;

    logic         clk;
    logic         reset_n;
    logic         ce;
    logic         we;
    logic [5:0]   addr;
    logic [127:0] din;
    logic [15:0]  bwe;
    logic [127:0] dout;
    logic [21:0]  dout22;

    int checks;
    int failures;

    sram1p_bwe #(.DEPTH(64), .WIDTH(128)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .addr    (addr),
        .din     (din),
        .we      (we),
        .bwe     (bwe),
        .dout    (dout)
    );

    sram1p_bwe #(.DEPTH(64), .WIDTH(22)) u_dut22 (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .addr    (addr),
        .din     (din[21:0]),
        .we      (we),
        .bwe     (bwe[2:0]),
        .dout    (dout22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value plus a known-bit mask per word; unknown bits never compared.
    logic [127:0] m128 [64];
    logic [127:0] k128 [64];
    logic [21:0]  m22  [64];
    logic [21:0]  k22  [64];
    int           ma;
    bit           ma_known;

    always @(posedge clk) begin
        if (!reset_n) begin
            ma       = 0;
            ma_known = 1'b1;
        end else begin
            if (ce && we) begin
                for (int b = 0; b < 128; b++) begin
                    if (bwe[b/8]) begin
                        m128[addr][b] = din[b];
                        k128[addr][b] = 1'b1;
                    end
                end
                for (int b = 0; b < 22; b++) begin
                    if (bwe[b/8]) begin
                        m22[addr][b] = din[b];
                        k22[addr][b] = 1'b1;
                    end
                end
            end
            if (ce) begin
                ma = int'(addr);
            end
        end
    end

    always @(negedge clk) begin
        if (ma_known) begin
            if (k128[ma] != '0) begin
                checks++;
                if (((dout ^ m128[ma]) & k128[ma]) != '0) begin
                    failures++;
                    $display("FAIL model128 t=%0t addr=%0d got=%h exp=%h known=%h",
                             $time, ma, dout, m128[ma], k128[ma]);
                end
            end
            if (k22[ma] != '0) begin
                checks++;
                if (((dout22 ^ m22[ma]) & k22[ma]) != '0) begin
                    failures++;
                    $display("FAIL model22 t=%0t addr=%0d got=%h exp=%h known=%h",
                             $time, ma, dout22, m22[ma], k22[ma]);
                end
            end
        end
    end

    task automatic step(input bit rn, input bit c, input bit w, input int a,
                        input logic [127:0] d, input logic [15:0] b);
        reset_n = rn;
        ce      = c;
        we      = w;
        addr    = a[5:0];
        din     = d;
        bwe     = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk22(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    localparam logic [127:0] D0 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] D5 = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
    localparam logic [127:0] DA = 128'hAAAA5555_12345678_9ABCDEF0_0F0F0F0F;
    localparam logic [127:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
    localparam logic [127:0] DC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [127:0] DM = 128'h33333333_00000000_33333333_00000000;
    localparam logic [127:0] DN = 128'h99999999_88888888_77777777_66666666;
    localparam logic [127:0] DE = 128'hE0E0E0E0_1E1E1E1E_E1E1E1E1_0E0E0E0E;
    localparam logic [127:0] ONES = '1;

    initial begin
        checks   = 0;
        failures = 0;
        ma       = 0;
        ma_known = 1'b0;
        for (int i = 0; i < 64; i++) begin
            k128[i] = '0;
            k22[i]  = '0;
            m128[i] = '0;
            m22[i]  = '0;
        end
        reset_n = 1'b0;
        ce      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        din     = '0;
        bwe     = '0;

        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, '0, '0);

        // Write-through on the same address as the held one.
        step(1, 1, 1, 0, D0, 16'hFFFF);
        chk128("wr_through_addr0", dout, D0);
        step(1, 1, 1, 5, D5, 16'hFFFF);
        chk128("wr_through_addr5", dout, D5);
        step(1, 1, 0, 5, '0, '0);
        chk128("full_read_addr5", dout, D5);

        // Byte lanes 4..7 cleared, everything else held at all-ones.
        step(1, 1, 1, 7, ONES, 16'hFFFF);
        step(1, 1, 1, 7, '0, 16'h00F0);
        chk128("partial_addr7", dout, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

        // Partial top lane of the 22-bit array.
        step(1, 1, 1, 63, 128'h3FFFFF, 16'h0007);
        chk22("w22_full", dout22, 22'h3FFFFF);
        step(1, 1, 1, 63, '0, 16'h0004);
        chk22("w22_top_lane", dout22, 22'h00FFFF);
        chk128("w128_low_addr63", dout & 128'hFFFFFF, 128'h00FFFF);

        // Chip-enable gating of both the write and the address register.
        step(1, 1, 1, 2, DC, 16'hFFFF);
        step(1, 1, 1, 3, DM, 16'hFFFF);
        step(1, 1, 1, 1, DA, 16'hFFFF);
        step(1, 0, 1, 2, DB, 16'hFFFF);
        chk128("ce0_holds_addr", dout, DA);
        step(1, 0, 0, 2, '0, '0);
        chk128("ce0_reads_prior", dout, DA);
        step(1, 1, 1, 1, DB, 16'h0000);
        chk128("bwe_zero_noop", dout, DA);
        step(1, 1, 0, 2, '0, '0);
        chk128("ce0_no_write_addr2", dout, DC);

        // Reset suppresses writes, keeps contents, returns the address to 0.
        step(1, 1, 1, 9, DN, 16'hFFFF);
        step(0, 1, 1, 3, DB, 16'hFFFF);
        step(0, 1, 1, 3, DB, 16'hFFFF);
        chk128("reset_reads_word0", dout, D0);
        step(1, 1, 0, 9, '0, '0);
        chk128("reset_keeps_addr9", dout, DN);
        step(1, 1, 0, 3, '0, '0);
        chk128("reset_blocks_write3", dout, DM);

        // Address change and write on the same edge.
        step(1, 1, 1, 11, DE, 16'hFFFF);
        chk128("new_addr_write", dout, DE);
        step(1, 1, 1, 11, ONES, 16'h8001);
        chk128("merge_lanes", dout, {8'hFF, DE[119:8], 8'hFF});

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 99) >= 3),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)),
                 {$urandom, $urandom, $urandom, $urandom},
                 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
